// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Value driven on the serial line whenever no frame is in flight.
    localparam logic LINE_IDLE = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter that feeds a downstream sequence detector.
// A word is accepted on a valid/ready handshake and shifted out one bit per
// cycle on the registered output j. Optional macro SER_PARITY_EN appends one
// odd-parity bit after the data bits.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             cl,
    input  logic             r,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             j,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic             j_n, busy_n, done_n, ready_n;
`ifdef SER_PARITY_EN
    logic             par, par_n;
`endif

    // Next-state and next-output decode; all outputs are registered below.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        j_n     = LINE_IDLE;
        busy_n  = busy;
        done_n  = 1'b0;
        ready_n = load_ready;
`ifdef SER_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                busy_n  = 1'b0;
                ready_n = 1'b1;
                if (load_valid && load_ready) begin
                    state_n = SHIFT;
                    busy_n  = 1'b1;
                    ready_n = 1'b0;
                    cnt_n   = CW'(WIDTH - 1);
                    // First bit goes straight to the line; the register keeps the rest.
                    j_n     = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
                    sreg_n  = (MSB_FIRST != 0) ? (din << 1) : (din >> 1);
`ifdef SER_PARITY_EN
                    par_n   = ~(^din);
`else
                    done_n  = (WIDTH == 1);
`endif
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
`ifdef SER_PARITY_EN
                    state_n = PARITY;
                    j_n     = par;
                    done_n  = 1'b1;
`else
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    ready_n = 1'b1;
`endif
                end else begin
                    cnt_n  = cnt - CW'(1);
                    j_n    = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
                    sreg_n = (MSB_FIRST != 0) ? (sreg << 1) : (sreg >> 1);
`ifndef SER_PARITY_EN
                    done_n = (cnt == CW'(1));
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                ready_n = 1'b1;
            end
`endif
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                ready_n = 1'b1;
            end
        endcase
    end

    // State and output registers; reset wins over any accept on the same edge.
    always_ff @(posedge cl) begin
        if (r) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            j          <= LINE_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef SER_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sreg       <= sreg_n;
            j          <= j_n;
            busy       <= busy_n;
            done       <= done_n;
            load_ready <= ready_n;
`ifdef SER_PARITY_EN
            par        <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed, table-driven bench for bit_serializer (MSB-first, LSB-first and
// WIDTH=1 instances). Expected frames follow SER_PARITY_EN when defined.
module tb_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int FL  = 9;
    localparam int FL1 = 2;
`else
    localparam int FL  = 8;
    localparam int FL1 = 1;
`endif

    logic       cl = 1'b0;
    logic       r  = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic [0:0] din1 = 1'b0;

    logic ready_m, j_m, busy_m, done_m;
    logic ready_l, j_l, busy_l, done_l;
    logic ready_1, j_1, busy_1, done_1;

    int checks   = 0;
    int failures = 0;

    always #5 cl = ~cl;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .cl(cl), .r(r), .din(din), .load_valid(load_valid),
        .load_ready(ready_m), .j(j_m), .busy(busy_m), .done(done_m));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .cl(cl), .r(r), .din(din), .load_valid(load_valid),
        .load_ready(ready_l), .j(j_l), .busy(busy_l), .done(done_l));

    bit_serializer #(.WIDTH(1), .MSB_FIRST(1)) u_w1 (
        .cl(cl), .r(r), .din(din1), .load_valid(load_valid),
        .load_ready(ready_1), .j(j_1), .busy(busy_1), .done(done_1));

    typedef struct {
        logic [7:0] din;
        logic       lsb;
        logic [7:0] bits;   // line values in cycle order, bits[7] = cycle 1
        logic       par;    // odd-parity bit
        int         det;    // cycle where detector pattern 1,0,1,1,0 completes (0 = none)
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge while all instances are idle.
    task automatic run_frame(input vec_t v);
        logic [4:0] hist;
        logic       jj, dd, bb, rr, expj;
        hist = '0;
        din = v.din;
        load_valid = 1'b1;
        @(posedge cl);
        @(negedge cl);
        load_valid = 1'b0;
        for (int k = 1; k <= FL; k++) begin
            jj = v.lsb ? j_l : j_m;
            dd = v.lsb ? done_l : done_m;
            bb = v.lsb ? busy_l : busy_m;
            rr = v.lsb ? ready_l : ready_m;
            expj = (k <= 8) ? v.bits[8-k] : v.par;
            chk($sformatf("frame_j din=%h k=%0d", v.din, k), jj, expj);
            chk($sformatf("frame_done din=%h k=%0d", v.din, k), dd, (k == FL));
            chk($sformatf("frame_busy din=%h k=%0d", v.din, k), bb, 1'b1);
            chk($sformatf("frame_ready din=%h k=%0d", v.din, k), rr, 1'b0);
            hist = {hist[3:0], jj};
            if (k == v.det)
                chk("detector_hit", (hist == 5'b10110), 1'b1);
            @(negedge cl);
        end
        jj = v.lsb ? j_l : j_m;
        rr = v.lsb ? ready_l : ready_m;
        bb = v.lsb ? busy_l : busy_m;
        dd = v.lsb ? done_l : done_m;
        chk("gap_j", jj, 1'b0);
        chk("gap_ready", rr, 1'b1);
        chk("gap_busy", bb, 1'b0);
        chk("gap_done", dd, 1'b0);
    endtask

    initial begin
        logic done_seen;
        tbl[0] = '{8'hB6, 1'b0, 8'b10110110, 1'b0, 0};
        tbl[1] = '{8'hB7, 1'b0, 8'b10110111, 1'b1, 0};
        tbl[2] = '{8'h00, 1'b0, 8'b00000000, 1'b1, 0};
        tbl[3] = '{8'hFF, 1'b0, 8'b11111111, 1'b1, 0};
        tbl[4] = '{8'h0D, 1'b1, 8'b10110000, 1'b0, 5};
        tbl[5] = '{8'hB6, 1'b1, 8'b01101101, 1'b0, 0};
        tbl[6] = '{8'h80, 1'b1, 8'b00000001, 1'b0, 0};

        // Reset state
        repeat (3) @(posedge cl);
        @(negedge cl);
        r = 1'b0;
        chk("rst_j", j_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_done", done_m, 1'b0);
        chk("rst_ready", ready_m, 1'b1);
        chk("rst_j_lsb", j_l, 1'b0);
        chk("rst_ready_lsb", ready_l, 1'b1);
        chk("rst_ready_w1", ready_1, 1'b1);
        chk("rst_j_w1", j_1, 1'b0);

        // Table of single frames
        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i]);
            @(negedge cl);
        end

        // load_valid held with a new word while busy: first frame unaffected,
        // next accept happens on the edge ending the idle gap cycle.
        din = 8'hB6;
        load_valid = 1'b1;
        @(posedge cl);
        @(negedge cl);
        din = 8'h5A;
        for (int k = 1; k <= FL; k++) begin
            chk($sformatf("hold_j k=%0d", k), j_m, (k <= 8) ? tbl[0].bits[8-k] : 1'b0);
            chk($sformatf("hold_busy k=%0d", k), busy_m, 1'b1);
            @(negedge cl);
        end
        chk("hold_gap_j", j_m, 1'b0);
        chk("hold_gap_ready", ready_m, 1'b1);
        chk("hold_gap_busy", busy_m, 1'b0);
        @(negedge cl);
        load_valid = 1'b0;
        chk("hold_next_busy", busy_m, 1'b1);
        chk("hold_next_j1", j_m, 1'b0);
        @(negedge cl);
        chk("hold_next_j2", j_m, 1'b1);
        repeat (FL + 2) @(negedge cl);

        // Reset on the edge ending cycle 4 aborts the frame without done.
        done_seen = 1'b0;
        din = 8'hFF;
        load_valid = 1'b1;
        @(posedge cl);
        @(negedge cl);
        load_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("abort_j k=%0d", k), j_m, 1'b1);
            done_seen = done_seen | done_m;
            if (k == 4) r = 1'b1;
            @(negedge cl);
        end
        r = 1'b0;
        done_seen = done_seen | done_m;
        chk("abort_j_after", j_m, 1'b0);
        chk("abort_busy_after", busy_m, 1'b0);
        chk("abort_ready_after", ready_m, 1'b1);
        chk("abort_no_done", done_seen, 1'b0);
        @(negedge cl);
        chk("abort_idle_j", j_m, 1'b0);
        chk("abort_idle_busy", busy_m, 1'b0);

        // Reset and load_valid on the same edge: no accept.
        din = 8'hFF;
        r = 1'b1;
        load_valid = 1'b1;
        @(posedge cl);
        @(negedge cl);
        r = 1'b0;
        load_valid = 1'b0;
        chk("rst_acc_busy", busy_m, 1'b0);
        chk("rst_acc_ready", ready_m, 1'b1);
        chk("rst_acc_j", j_m, 1'b0);
        chk("rst_acc_done", done_m, 1'b0);
        @(negedge cl);
        chk("rst_acc_busy2", busy_m, 1'b0);
        chk("rst_acc_j2", j_m, 1'b0);

        // WIDTH=1 frame
        din = 8'h00;
        din1 = 1'b1;
        load_valid = 1'b1;
        @(posedge cl);
        @(negedge cl);
        load_valid = 1'b0;
        chk("w1_j", j_1, 1'b1);
        chk("w1_busy", busy_1, 1'b1);
        chk("w1_done", done_1, (FL1 == 1));
        if (FL1 == 2) begin
            @(negedge cl);
            chk("w1_par_j", j_1, 1'b0);
            chk("w1_par_done", done_1, 1'b1);
        end
        @(negedge cl);
        chk("w1_gap_j", j_1, 1'b0);
        chk("w1_gap_ready", ready_1, 1'b1);
        chk("w1_gap_done", done_1, 1'b0);
        repeat (FL + 2) @(negedge cl);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; legal range 1..32.
REQ-002 Parameter MSB_FIRST, default 1, shift order; 1 = MSB first, 0 = LSB first.
REQ-003 cl  input  1  single clock; all state updates on posedge cl.
REQ-004 r  input  1  reset; synchronous and active-high, sampled on posedge cl.
REQ-005 din  input  WIDTH  parallel word to serialize; sampled only on an accepting edge.
REQ-006 load_valid  input  1  upstream asserts when din holds a word to send.
REQ-007 load_ready  output  1  high when a word can be accepted.
REQ-008 j  output  1  registered serial bit stream that feeds the downstream sequence detector.
REQ-009 busy  output  1  high while a frame is being shifted out.
REQ-010 done  output  1  one-cycle pulse during the final bit of a frame.

Function
REQ-011 Two-state FSM, IDLE and SHIFT; a PARITY state is added when the parity option is compiled in.
REQ-012 load_ready SHALL be 1 only in IDLE and SHALL be a registered output.
REQ-013 An accept SHALL occur on a posedge with load_valid=1 and load_ready=1; din is captured into the shift register.
REQ-014 On the accepting edge, j SHALL take the first data bit, busy SHALL go to 1 and the FSM SHALL enter SHIFT.
REQ-015 Each data bit SHALL be held on j for exactly one cycle; data bits occupy cycles 1..WIDTH after the accept.
REQ-016 Bit order SHALL be din[WIDTH-1] down to din[0] when MSB_FIRST=1, and din[0] up to din[WIDTH-1] otherwise.
REQ-017 The bit counter SHALL be $clog2(WIDTH)+1 bits wide, SHALL count down from WIDTH-1 and SHALL never wrap.
REQ-018 done SHALL be 1 exactly during the last bit of the frame (last data bit, or the parity bit when parity is enabled).
REQ-019 On the edge ending the last bit: j=0, busy=0, load_ready=1, FSM=IDLE.
REQ-020 Back-to-back frames SHALL have a minimum gap of one IDLE cycle with j=0.
REQ-021 In IDLE, j SHALL be 0 (line-idle value).
REQ-022 load_valid and din SHALL be ignored while busy; no buffering and no error flag.
REQ-023 With WIDTH=1, a frame SHALL be one data cycle with done asserted in that same cycle.

Reset
REQ-024 When r=1 at a posedge, the next state SHALL be: FSM=IDLE, j=0, busy=0, done=0, load_ready=1, shift register and counter cleared.
REQ-025 Reset mid-frame SHALL abort the frame with no done pulse; reset has priority over an accept on the same edge.

Configuration
REQ-026 Macro SER_PARITY_EN defined: after the data bits, one PARITY cycle SHALL drive odd parity on j, making the total count of 1s in data plus parity odd; the frame is WIDTH+1 cycles.
REQ-027 Macro SER_PARITY_EN undefined: no PARITY state and no parity logic; the frame is WIDTH cycles.

Structure
REQ-028 Package ser_pkg SHALL hold the state_t enum (IDLE, SHIFT, PARITY) and the constant LINE_IDLE = 1'b0.
REQ-029 The block SHALL be a single module with no sub-module; the counter and shift register are inline.

Verification
REQ-030 Parity off, WIDTH=8, MSB_FIRST=1, din=8'hB6 accepted at edge 0 -> j=1,0,1,1,0,1,1,0 in cycles 1-8; done=1 in cycle 8 only; cycle 9: j=0, load_ready=1.
REQ-031 MSB_FIRST=0, din=8'h0D -> j=1,0,1,1,0,0,0,0; the serializer driving the detector (which flags the sequence 1,0,1,1,0) SHALL produce a detector output of 1 in cycle 5.
REQ-032 SER_PARITY_EN defined, din=8'hB6 (five 1s) -> cycle 9: j=0 and done=1; din=8'hB7 -> cycle 9: j=1.
REQ-033 load_valid held at 1 with a new din during cycles 1-8 -> din ignored, first frame bits unchanged; next accept at edge 9; j=0 during cycle 9.
REQ-034 r=1 at the edge ending cycle 4 of a frame -> next cycle: j=0, busy=0, load_ready=1; done never asserted for that frame.
REQ-035 r=1 and load_valid=1 on the same edge -> no accept; IDLE outputs hold.
